// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte requesters.
// Each transfer runs grant -> one-cycle write strobe -> busy rise -> busy fall -> ack.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int ID_W         = 2,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          ack,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic                      timeout_err,
   output logic [DATA_W-1:0]         Tx_DATA,
   output logic                      Tx_WR,
   input  logic                      Tx_BUSY
);

   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_DONE
   } state_t;

   state_t              state_q;
   logic [ID_W-1:0]     rr_ptr_q;
   logic [ID_W-1:0]     grant_id_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;
   logic [DATA_W-1:0]   tx_data_q;
   logic                tx_wr_q;
   logic [N_REQ-1:0]    ack_q;
   logic                busy_q;
   logic                timeout_err_q;

   logic [N_REQ-1:0]    req_rot;
   logic                pick_vld;
   logic [ID_W:0]       pick_sum;
   logic [ID_W:0]       pick_wrap;
   logic [ID_W-1:0]     pick_id;
   logic [DATA_W-1:0]   pick_data;
   logic [ID_W-1:0]     next_ptr_d;

   // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit wins.
   assign req_rot = N_REQ'({req, req} >> rr_ptr_q);

   always_comb begin
      pick_vld = 1'b0;
      pick_sum = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            pick_vld = 1'b1;
            pick_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         end
      end
      pick_wrap = pick_sum - (ID_W+1)'(N_REQ);
      pick_id   = (pick_sum >= (ID_W+1)'(N_REQ)) ? pick_wrap[ID_W-1:0] : pick_sum[ID_W-1:0];
   end

   always_comb begin
      pick_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_id == ID_W'(i)) begin
            pick_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      next_ptr_d = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
      cnt_d      = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         cnt_q         <= '0;
         tx_data_q     <= '0;
         tx_wr_q       <= 1'b0;
         ack_q         <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         tx_wr_q       <= 1'b0;
         ack_q         <= '0;
         timeout_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // A uart that is already busy blocks any new grant.
               if (!Tx_BUSY && pick_vld) begin
                  grant_id_q <= pick_id;
                  tx_data_q  <= pick_data;
                  tx_wr_q    <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= S_WRITE;
               end
            end
            S_WRITE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               // Busy arriving on the limit cycle still counts as success.
               if (Tx_BUSY) begin
                  state_q <= S_WAIT_DONE;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_d == CNT_W'(BUSY_TIMEOUT - 1)) begin
                     timeout_err_q <= 1'b1;
                     rr_ptr_q      <= next_ptr_d;
                     busy_q        <= 1'b0;
                     state_q       <= S_IDLE;
                  end
               end
            end
            S_WAIT_DONE: begin
               if (!Tx_BUSY) begin
                  ack_q   <= N_REQ'(1) << grant_id_q;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               rr_ptr_q <= next_ptr_d;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ack         = ack_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;
   assign Tx_DATA     = tx_data_q;
   assign Tx_WR       = tx_wr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle vector table, directed corner sequences and a
// randomized run against a transaction-level model of requester queues and the uart.
module tb_uart_tx_arbiter;

   localparam int N_REQ  = 4;
   localparam int ID_W   = 2;
   localparam int DATA_W = 8;
   localparam int BT     = 16;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        ack;
   logic [ID_W-1:0]         grant_id;
   logic                    busy;
   logic                    timeout_err;
   logic [DATA_W-1:0]       Tx_DATA;
   logic                    Tx_WR;
   logic                    Tx_BUSY;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W), .BUSY_TIMEOUT(BT)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
      .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
      .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_BUSY(Tx_BUSY)
   );

   typedef struct {
      int          reps;
      logic [3:0]  req;
      logic [31:0] data;
      logic        txb;
      logic        wr;
      logic [3:0]  ack;
      logic        bsy;
      logic [1:0]  gid;
      logic [7:0]  txd;
      logic        to;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      req      = '0;
      req_data = '0;
      Tx_BUSY  = 1'b0;
      step();
      check("reset_state", {Tx_WR, ack, grant_id, busy, timeout_err, Tx_DATA}, 64'd0);
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic wait_wr(input string name, input logic [1:0] gid, input logic [7:0] data);
      int  n;
      logic ack_seen;
      n = 0;
      ack_seen = 1'b0;
      do begin
         step();
         n++;
         if (ack !== 4'b0) ack_seen = 1'b1;
      end while (Tx_WR !== 1'b1 && n < 40);
      check({name, "_wr"}, {Tx_WR, grant_id, Tx_DATA}, {1'b1, gid, data});
      check({name, "_noack"}, ack_seen, 1'b0);
   endtask

   task automatic wait_ack(input string name, input logic [3:0] exp_ack);
      int n;
      int extra_wr;
      n = 0;
      extra_wr = 0;
      do begin
         step();
         n++;
         if (Tx_WR === 1'b1) extra_wr++;
      end while (ack === 4'b0 && n < 40);
      check({name, "_ack"}, ack, exp_ack);
      check({name, "_one_wr"}, extra_wr, 0);
   endtask

   task automatic serve(input logic [1:0] id, input logic [7:0] data);
      wait_wr("serve", id, data);
      Tx_BUSY = 1'b1;
      repeat (2) step();
      Tx_BUSY = 1'b0;
      wait_ack("serve", 4'b0001 << id);
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (p + k) % 4;
         if (r[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   // Random-run model state
   logic [7:0] q [4][$];
   int  mptr, cur, exp_wr_step, exp_ack_step, exp_to_step, idle_from;
   bit  granted;
   int  pend, hold, hold_len, pushes, acks, left;
   logic [7:0] exp_data;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      do_reset();

      // Single request on requester 2, then timeout on requester 0, then rr_ptr check.
      tbl.push_back('{1,  4'b0100, 32'h00A5_0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b0});
      tbl.push_back('{1,  4'b0000, 32'h005A_0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b0});
      tbl.push_back('{10, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b0});
      tbl.push_back('{1,  4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 8'hA5, 1'b0});
      tbl.push_back('{1,  4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'hA5, 1'b0});
      tbl.push_back('{2,  4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 8'hA5, 1'b0});
      tbl.push_back('{1,  4'b0001, 32'h0000_0077, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h77, 1'b0});
      tbl.push_back('{15, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h77, 1'b0});
      tbl.push_back('{1,  4'b0000, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h77, 1'b1});
      tbl.push_back('{1,  4'b0011, 32'h0000_2211, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h22, 1'b0});

      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++) begin
            req      = tbl[i].req;
            req_data = tbl[i].data;
            Tx_BUSY  = tbl[i].txb;
            step();
            check($sformatf("vec%0d", i),
                  {Tx_WR, ack, busy, grant_id, Tx_DATA, timeout_err},
                  {tbl[i].wr, tbl[i].ack, tbl[i].bsy, tbl[i].gid, tbl[i].txd, tbl[i].to});
         end
      end

      // Uart already busy when the request arrives.
      do_reset();
      Tx_BUSY  = 1'b1;
      req      = 4'b0001;
      req_data = 32'h0000_00C3;
      repeat (4) begin
         step();
         check("held_no_wr", {Tx_WR, busy}, 2'b00);
      end
      Tx_BUSY = 1'b0;
      step();
      check("held_wr", {Tx_WR, grant_id, Tx_DATA}, {1'b1, 2'd0, 8'hC3});
      req     = 4'b0000;
      Tx_BUSY = 1'b1;
      repeat (3) step();
      Tx_BUSY = 1'b0;
      wait_ack("held", 4'b0001);

      // Asynchronous reset during WAIT_DONE, then retransmission.
      do_reset();
      req      = 4'b0001;
      req_data = 32'h0000_003C;
      step();
      check("rst_seq_wr", Tx_WR, 1'b1);
      Tx_BUSY = 1'b1;
      repeat (3) step();
      check("rst_seq_busy", busy, 1'b1);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", {Tx_WR, ack, grant_id, busy, timeout_err, Tx_DATA}, 64'd0);
      Tx_BUSY = 1'b0;
      repeat (2) begin
         step();
         check("rst_no_ack", ack, 4'b0000);
      end
      reset = 1'b1;
      wait_wr("retx", 2'd0, 8'h3C);
      Tx_BUSY = 1'b1;
      repeat (2) step();
      Tx_BUSY = 1'b0;
      req     = 4'b0000;
      wait_ack("retx", 4'b0001);

      // Busy rises on the very cycle the counter would expire.
      do_reset();
      req      = 4'b0010;
      req_data = 32'h0000_9E00;
      step();
      check("edge_wr", Tx_WR, 1'b1);
      req = 4'b0000;
      repeat (15) step();
      Tx_BUSY = 1'b1;
      step();
      check("edge_busy_no_to", {timeout_err, busy}, 2'b01);
      Tx_BUSY = 1'b0;
      wait_ack("edge", 4'b0010);

      // All four requesters held high.
      do_reset();
      req      = 4'b1111;
      req_data = 32'h4433_2211;
      serve(2'd0, 8'h11);
      serve(2'd1, 8'h22);
      serve(2'd2, 8'h33);
      serve(2'd3, 8'h44);
      serve(2'd0, 8'h11);

      // Fairness after requester 1.
      do_reset();
      req      = 4'b0010;
      req_data = 32'h0000_9900;
      serve(2'd1, 8'h99);
      req      = 4'b1001;
      req_data = 32'hD400_00A0;
      serve(2'd3, 8'hD4);
      serve(2'd0, 8'hA0);

      // Randomized run against the queue/uart model.
      do_reset();
      for (int i = 0; i < 4; i++) q[i].delete();
      mptr = 0; cur = 0; granted = 0; idle_from = cyc;
      exp_wr_step = -1; exp_ack_step = -1; exp_to_step = -1;
      pend = 0; hold = 0; hold_len = 0; pushes = 0; acks = 0;
      exp_data = '0;
      for (int n = 0; n < 8000; n++) begin
         step();
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               Tx_BUSY = 1'b1;
               hold = hold_len;
            end
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) begin
               Tx_BUSY = 1'b0;
               exp_ack_step = cyc + 1;
            end
         end
         check("rnd_wr", Tx_WR, cyc == exp_wr_step);
         if (cyc == exp_wr_step) begin
            check("rnd_grant", {grant_id, Tx_DATA}, {cur[1:0], exp_data});
            if ($urandom_range(5) == 0) begin
               exp_to_step = cyc + BT;
            end else begin
               pend     = $urandom_range(1, 3);
               hold_len = $urandom_range(1, 6);
            end
         end
         check("rnd_ack", ack, (cyc == exp_ack_step) ? (4'b0001 << cur) : 4'b0000);
         if (cyc == exp_ack_step) begin
            void'(q[cur].pop_front());
            acks++;
            mptr = (cur + 1) % 4;
            idle_from = cyc + 1;
            granted = 0;
         end
         check("rnd_to", timeout_err, cyc == exp_to_step);
         if (cyc == exp_to_step) begin
            mptr = (cur + 1) % 4;
            idle_from = cyc;
            granted = 0;
         end
         if (n < 2500) begin
            for (int i = 0; i < 4; i++) begin
               if (q[i].size() < 3 && $urandom_range(9) == 0) begin
                  q[i].push_back(8'($urandom));
                  pushes++;
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            req[i] = (q[i].size() > 0);
            req_data[i*8 +: 8] = (q[i].size() > 0) ? q[i][0] : 8'h00;
         end
         if (!granted && cyc >= idle_from && req != 4'b0 && !Tx_BUSY) begin
            cur = pick(req, mptr);
            exp_data = q[cur][0];
            exp_wr_step = cyc + 1;
            granted = 1;
         end
         if (n >= 2500 && req == 4'b0 && !granted) break;
      end
      left = 0;
      for (int i = 0; i < 4; i++) left += q[i].size();
      check("rnd_drained", left, 0);
      check("rnd_ack_count", acks, pushes);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among N_REQ byte requesters using round-robin arbitration.
- Sits between the requester blocks and the uart instance. Drives its Tx_DATA and Tx_WR inputs and monitors its Tx_BUSY output.
- Sequences each transfer as grant, one-cycle write strobe, wait for busy rise, wait for busy fall, acknowledge.
- Recovers from a transmitter that never starts by means of a timeout.

Parameters:
- N_REQ, 4, number of requesters.
- ID_W, 2, width of grant_id; must equal clog2(N_REQ).
- DATA_W, 8, byte width.
- BUSY_TIMEOUT, 16, maximum cycles in WAIT_BUSY before a transfer is abandoned.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request, one bit per requester.
- req_data  in  N_REQ*DATA_W  requester i's byte on bits [i*DATA_W +: DATA_W].
- ack  out  N_REQ  one-cycle pulse on the served requester's bit when its byte has been sent.
- grant_id  out  ID_W  index of the requester currently being served.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  one-cycle pulse when a transfer is abandoned.
- Tx_DATA  out  DATA_W  byte to the uart.
- Tx_WR  out  1  write strobe to the uart.
- Tx_BUSY  in  1  uart transmitter busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - Tx_WR=0, Tx_DATA=0, ack=0, grant_id=0, busy=0, timeout_err=0.
  - Asserting reset mid-transfer takes effect immediately: Tx_WR drops, no ack is issued, and no memory of the transfer remains.
- All outputs are registered.
- States: IDLE, WRITE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE:
  - If Tx_BUSY=1, stay in IDLE; no grant (the uart is already busy).
  - Else if any req bit is set, select the first set bit scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ... N_REQ-1, 0, ...).
  - On selection, latch grant_id and Tx_DATA from that requester's req_data slice, then go to WRITE.
  - With no request, stay in IDLE; Tx_DATA holds its last value.
- WRITE:
  - Tx_WR=1 for exactly this one cycle; go to WAIT_BUSY and clear the counter.
  - Tx_DATA and grant_id stay stable from WRITE until the next grant.
- WAIT_BUSY:
  - Tx_WR=0. If Tx_BUSY=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1 without Tx_BUSY, pulse timeout_err, issue no ack, set rr_ptr=grant_id+1 mod N_REQ, and go to IDLE.
- WAIT_DONE: stay while Tx_BUSY=1. On Tx_BUSY=0, go to DONE.
- DONE:
  - ack[grant_id]=1 for this one cycle; set rr_ptr=grant_id+1 mod N_REQ; go to IDLE.
  - No arbitration happens in DONE. Requesters use this cycle to drop req or to present their next byte.
- Latency, with Tx_BUSY=0 at request time:
  - req sampled in IDLE at cycle T; Tx_WR high at T+1.
  - ack is high one cycle after the first cycle in which Tx_BUSY is sampled low in WAIT_DONE.
- Request and data rules:
  - req_data and req changes after the grant are ignored. A requester dropping req mid-transfer still receives its ack.
  - A requester holding req high after its ack is served again only after every other active requester has had a turn.
- Simultaneous events:
  - Tx_BUSY rising in the same cycle the counter hits its limit counts as success; the transfer proceeds to WAIT_DONE with no timeout_err.
- rr_ptr wraps from N_REQ-1 to 0.

Test Plan:
- Single request, req=4'b0100, req_data byte 2=0xA5; uart model raises Tx_BUSY 2 cycles after Tx_WR and holds it 10 cycles -> exactly one Tx_WR pulse with Tx_DATA=0xA5, grant_id=2, ack=4'b0100 for one cycle, busy low afterwards.
- All four requesters held high with bytes 0x11/0x22/0x33/0x44 -> Tx_DATA sequence 0x11, 0x22, 0x33, 0x44, 0x11; ack order bit 0, 1, 2, 3, 0; one Tx_WR per byte.
- Fairness: after requester 1 is served, req=4'b1001 -> requester 3 granted before requester 0.
- Timeout: model never raises Tx_BUSY, BUSY_TIMEOUT=16 -> timeout_err pulses 16 cycles after Tx_WR, ack stays 0, return to IDLE, rr_ptr advanced.
- Tx_BUSY=1 already asserted when req=4'b0001 rises -> no Tx_WR until Tx_BUSY falls, then Tx_WR on the following cycle.
- reset driven low during WAIT_DONE -> all outputs go to reset values without waiting for a clock edge and no ack occurs. After release with req still high, requester 0's byte is retransmitted.
